ysyx_041461_mem_lsu: RTL

Load/store unit of the MEM stage and consumer end of the EXE→MEM pipeline register. It takes the held register outputs (valid, MEM control, computed address, store data), runs one access on the 64-bit data bus with a valid/ready request and a response strobe, and returns aligned, extended load data to the WB path. While an access is outstanding it drives `mem_stall`, which the pipeline inverts into the MEM register enable so the instruction is held.

---
 rtl/ysyx_041461_mem_lsu.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ysyx_041461_mem_lsu.sv
// MEM-stage load/store unit: runs one data-bus access per held MEM instruction
// and returns aligned, extended load data with a one-cycle done pulse.
module ysyx_041461_mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid_in,
  input  logic [3:0]  lsu_MEM_ctrl_in,
  input  logic [63:0] lsu_addr_in,
  input  logic [63:0] lsu_wdata_in,
  output logic        mem_stall,
  output logic        lsu_done,
  output logic [63:0] lsu_rdata,
  output logic        lsu_misalign,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic [63:0] dbus_req_addr,
  output logic        dbus_req_wen,
  output logic [63:0] dbus_req_wdata,
  output logic [7:0]  dbus_req_wmask,
  input  logic        dbus_resp_valid,
  input  logic [63:0] dbus_resp_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic        misalign_q;

  // log2 of access size in bytes; only meaningful for codes 1..11
  function automatic logic [1:0] size_lg(input logic [3:0] op);
    case (op)
      4'd1, 4'd5, 4'd8: size_lg = 2'd0;
      4'd2, 4'd6, 4'd9: size_lg = 2'd1;
      4'd3, 4'd7, 4'd10: size_lg = 2'd2;
      default: size_lg = 2'd3;
    endcase
  endfunction

  logic       is_mem_op, mis_in;
  logic [1:0] lg_in, lg_q;

  assign is_mem_op = lsu_valid_in && (lsu_MEM_ctrl_in >= 4'd1) && (lsu_MEM_ctrl_in <= 4'd11);
  assign lg_in     = size_lg(lsu_MEM_ctrl_in);
  assign lg_q      = size_lg(op_q);

  always_comb begin
    mis_in = 1'b0;
    case (lg_in)
      2'd1: mis_in = lsu_addr_in[0];
      2'd2: mis_in = |lsu_addr_in[1:0];
      2'd3: mis_in = |lsu_addr_in[2:0];
      default: mis_in = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (is_mem_op) state_nxt = mis_in ? S_DONE : S_REQ;
      S_REQ:  if (dbus_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (dbus_resp_valid) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [63:0] raw, load_ext;
  assign raw = dbus_resp_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = '0;
    case (op_q)
      4'd1: load_ext = {{56{raw[7]}},  raw[7:0]};
      4'd2: load_ext = {{48{raw[15]}}, raw[15:0]};
      4'd3: load_ext = {{32{raw[31]}}, raw[31:0]};
      4'd4: load_ext = raw;
      4'd5: load_ext = {56'd0, raw[7:0]};
      4'd6: load_ext = {48'd0, raw[15:0]};
      4'd7: load_ext = {32'd0, raw[31:0]};
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (is_mem_op) begin
          if (mis_in) begin
            misalign_q <= 1'b1;
            rdata_q    <= '0;
          end else begin
            op_q    <= lsu_MEM_ctrl_in;
            addr_q  <= lsu_addr_in;
            wdata_q <= lsu_wdata_in;
          end
        end
        S_WAIT: if (dbus_resp_valid) rdata_q <= load_ext;
        // results are only meaningful with lsu_done, so clear them on exit
        S_DONE: begin
          rdata_q    <= '0;
          misalign_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  logic in_req, is_store;
  logic [7:0] base_mask;
  assign in_req   = (state == S_REQ);
  assign is_store = op_q[3];

  always_comb begin
    base_mask = 8'h00;
    case (lg_q)
      2'd0: base_mask = 8'h01;
      2'd1: base_mask = 8'h03;
      2'd2: base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  assign dbus_req_valid = in_req;
  assign dbus_req_addr  = in_req ? {addr_q[63:3], 3'b000} : '0;
  assign dbus_req_wen   = in_req && is_store;
  assign dbus_req_wdata = (in_req && is_store) ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
  assign dbus_req_wmask = (in_req && is_store) ? (base_mask << addr_q[2:0]) : 8'h00;

  assign mem_stall    = (state == S_REQ) || (state == S_WAIT) || ((state == S_IDLE) && is_mem_op);
  assign lsu_done     = (state == S_DONE);
  assign lsu_rdata    = rdata_q;
  assign lsu_misalign = misalign_q;

endmodule
